// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 serial receiver with stop-bit check and FWFT receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_in,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic                          busy
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]  CNT_WRAP  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]    DEPTH_VAL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state;
    logic            sync1;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rxs   <= sync1;
        end
    end

    // Push is combinational on the stop-sample cycle so the byte lands on that same edge.
    assign push     = (state == S_STOP) && (cnt == CNT_WRAP) && rxs;
    assign rx_count = wr_ptr - rd_ptr;
    assign rd_valid = (wr_ptr != rd_ptr);
    assign full     = (rx_count == DEPTH_VAL);
    assign pop      = rd_valid & rd_ready;
    assign accept   = push & (~full | pop);
    assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) state <= S_START;
                end
                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == CNT_WRAP) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == CNT_WRAP) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    // Hold here until the line returns high so a stuck-low line cannot start frames.
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)    rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && !accept) overrun <= 1'b1;
            else if (err_clr)    overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= shift;
    end

endmodule
`default_nettype wire
